// File: rtl/monster_spawn_scheduler_if.sv
// Spawn-path bus between the monster FSMs and the spawn scheduler.
// The master side is the scheduler, and the slave side is the monster/sprite datapath.
interface monster_spawn_scheduler_if #(
   parameter int NUM_MONSTERS = 4
);
   localparam int IW = $clog2(NUM_MONSTERS);

   // req is a level that stays high until served. ack is a one-cycle pulse from the granted
   // monster while its grant is high. grant is one-hot and is held for the whole handshake.
   logic                    enable;
   logic [NUM_MONSTERS-1:0] req;
   logic [NUM_MONSTERS-1:0] ack;
   logic [NUM_MONSTERS-1:0] grant;
   logic [IW-1:0]           grant_idx;
   logic                    busy;
   logic                    timeout_pulse;
   logic [15:0]             spawn_count;

   modport master (
      input  enable, req, ack,
      output grant, grant_idx, busy, timeout_pulse, spawn_count
   );

   modport slave (
      output enable, req, ack,
      input  grant, grant_idx, busy, timeout_pulse, spawn_count
   );
endinterface

// File: rtl/monster_spawn_scheduler.sv
// Round-robin arbiter for the single monster-spawn path, with an ack timeout and a cooldown.
// The cooldown is enforced between spawns, and one counter is shared by the GRANT and COOLDOWN states.
module monster_spawn_scheduler #(
   parameter int NUM_MONSTERS = 4,
   parameter int SPAWN_GAP    = 25000000,
   parameter int ACK_TIMEOUT  = 1024
) (
   input  logic                         Clk,
   input  logic                         Reset_n,
   monster_spawn_scheduler_if.master    bus,
   output logic [1:0]                   o_dbg_state
);
   localparam int IW      = $clog2(NUM_MONSTERS);
   localparam int MAX_CNT = (SPAWN_GAP > ACK_TIMEOUT) ? SPAWN_GAP : ACK_TIMEOUT;
   localparam int CW      = $clog2(MAX_CNT) + 1;
   localparam logic [CW-1:0] GAP_LAST = CW'(SPAWN_GAP - 1);
   localparam logic [CW-1:0] TO_LAST  = CW'(ACK_TIMEOUT - 1);

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_GRANT    = 2'd1,
      ST_COOLDOWN = 2'd2
   } state_t;

   state_t                  r_state;
   logic [CW-1:0]           r_cnt;
   logic [NUM_MONSTERS-1:0] r_grant;
   logic [IW-1:0]           r_grant_idx;
   logic [IW-1:0]           r_ptr;
   logic                    r_timeout;
   logic                    r_busy;
   logic [15:0]             r_spawn_count;

   logic                    w_found;
   logic [IW-1:0]           w_pick;
   logic [IW-1:0]           w_ptr_next;

   // The search starts at r_ptr and wraps, so the monster served last has the lowest priority.
   always_comb begin
      w_found = 1'b0;
      w_pick  = '0;
      for (int i = 0; i < NUM_MONSTERS; i++) begin
         if (!w_found && bus.req[IW'((int'(r_ptr) + i) % NUM_MONSTERS)]) begin
            w_found = 1'b1;
            w_pick  = IW'((int'(r_ptr) + i) % NUM_MONSTERS);
         end
      end
   end

   assign w_ptr_next = (r_grant_idx == IW'(NUM_MONSTERS - 1)) ? '0 : r_grant_idx + 1'b1;

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         r_state       <= ST_COOLDOWN;
         r_cnt         <= '0;
         r_grant       <= '0;
         r_grant_idx   <= '0;
         r_ptr         <= '0;
         r_timeout     <= 1'b0;
         r_busy        <= 1'b1;
         r_spawn_count <= '0;
      end else begin
         r_timeout <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (bus.enable && w_found) begin
                  r_grant     <= NUM_MONSTERS'(1) << w_pick;
                  r_grant_idx <= w_pick;
                  r_cnt       <= '0;
                  r_busy      <= 1'b1;
                  r_state     <= ST_GRANT;
               end
            end
            ST_GRANT: begin
               // An ack in the cycle where the timeout limit is reached still counts as a completed spawn.
               if (bus.ack[r_grant_idx]) begin
                  r_grant <= '0;
                  r_ptr   <= w_ptr_next;
                  r_cnt   <= '0;
                  r_state <= ST_COOLDOWN;
                  if (r_spawn_count != 16'hFFFF) r_spawn_count <= r_spawn_count + 16'd1;
               end else if (r_cnt == TO_LAST) begin
                  r_grant   <= '0;
                  r_ptr     <= w_ptr_next;
                  r_cnt     <= '0;
                  r_timeout <= 1'b1;
                  r_state   <= ST_COOLDOWN;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            ST_COOLDOWN: begin
               if (r_cnt == GAP_LAST) begin
                  r_cnt   <= '0;
                  r_busy  <= 1'b0;
                  r_state <= ST_IDLE;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            default: begin
               r_grant <= '0;
               r_cnt   <= '0;
               r_busy  <= 1'b1;
               r_state <= ST_COOLDOWN;
            end
         endcase
      end
   end

   assign bus.grant         = r_grant;
   assign bus.grant_idx     = r_grant_idx;
   assign bus.busy          = r_busy;
   assign bus.timeout_pulse = r_timeout;
   assign bus.spawn_count   = r_spawn_count;
   assign o_dbg_state       = r_state;
endmodule

// File: tb/tb_monster_spawn_scheduler.sv
// Bench for monster_spawn_scheduler with NUM_MONSTERS=4, SPAWN_GAP=8 and ACK_TIMEOUT=16.
// It combines directed vectors, hand-written corner sequences, and random traffic checked against a behavioural model.
module tb_monster_spawn_scheduler;
   localparam int N   = 4;
   localparam int GAP = 8;
   localparam int TO  = 16;

   logic       Clk;
   logic       Reset_n;
   logic       en;
   logic [3:0] req;
   logic [3:0] ack;
   logic [1:0] dbg_state;

   int n_checks = 0;
   int n_fail   = 0;

   monster_spawn_scheduler_if #(.NUM_MONSTERS(N)) bus_if();
   assign bus_if.enable = en;
   assign bus_if.req    = req;
   assign bus_if.ack    = ack;

   monster_spawn_scheduler #(
      .NUM_MONSTERS(N),
      .SPAWN_GAP   (GAP),
      .ACK_TIMEOUT (TO)
   ) dut (
      .Clk        (Clk),
      .Reset_n    (Reset_n),
      .bus        (bus_if),
      .o_dbg_state(dbg_state)
   );

   initial begin
      Clk = 1'b0;
      forever #5 Clk = ~Clk;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Behavioural model: the current owner or -1, the remaining cooldown cycles, and the cycles the grant has been visible.
   int         m_owner;
   int         m_last;
   int         m_held;
   int         m_wait;
   int         m_idx;
   logic [15:0] m_count;
   logic        m_tpulse;

   task automatic model_reset();
      m_owner  = -1;
      m_last   = N - 1;
      m_held   = 0;
      m_wait   = GAP;
      m_idx    = 0;
      m_count  = 16'd0;
      m_tpulse = 1'b0;
   endtask

   task automatic model_step();
      int  c;
      logic found;
      if (!Reset_n) begin
         model_reset();
         return;
      end
      m_tpulse = 1'b0;
      if (m_owner >= 0) begin
         if (ack[m_owner[1:0]]) begin
            if (m_count != 16'hFFFF) m_count = m_count + 16'd1;
            m_last  = m_owner;
            m_owner = -1;
            m_wait  = GAP;
         end else if (m_held == TO) begin
            m_tpulse = 1'b1;
            m_last   = m_owner;
            m_owner  = -1;
            m_wait   = GAP;
         end else begin
            m_held++;
         end
      end else if (m_wait > 0) begin
         m_wait--;
      end else if (en && req != 4'd0) begin
         found = 1'b0;
         for (int i = 1; i <= N; i++) begin
            c = (m_last + i) % N;
            if (!found && req[c[1:0]]) begin
               found   = 1'b1;
               m_owner = c;
               m_idx   = c;
               m_held  = 1;
            end
         end
      end
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Advance one clock, step the model with the inputs the DUT sampled, then compare after the edge has settled.
   task automatic tick();
      logic [31:0] mg;
      @(posedge Clk);
      model_step();
      #1;
      mg = (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0;
      check("cyc_grant",     32'(bus_if.grant),         mg);
      check("cyc_grant_idx", 32'(bus_if.grant_idx),     32'(m_idx));
      check("cyc_busy",      32'(bus_if.busy),          32'((m_owner >= 0) || (m_wait > 0)));
      check("cyc_timeout",   32'(bus_if.timeout_pulse), 32'(m_tpulse));
      check("cyc_count",     32'(bus_if.spawn_count),   32'(m_count));
      check("cyc_onehot0",   32'($onehot0(bus_if.grant)), 32'd1);
   endtask

   task automatic wait_grant(input string name);
      int n;
      n = 0;
      while (bus_if.grant == 4'd0 && n < 100) begin
         tick();
         n++;
      end
      check({name, "_wait"}, 32'(n < 100), 32'd1);
   endtask

   task automatic serve(input logic [3:0] exp, input int delay, input string name);
      wait_grant(name);
      check(name, 32'(bus_if.grant), 32'(exp));
      repeat (delay) tick();
      ack = exp;
      tick();
      ack = 4'd0;
   endtask

   typedef struct {
      logic        en;
      logic [3:0]  req;
      int          delay;
      logic [3:0]  exp_grant;
      logic [15:0] exp_count;
   } vec_t;

   vec_t vecs[8];

   initial begin
      int n;
      int r;

      vecs[0] = '{1'b1, 4'b1111, 2, 4'b0010, 16'd2};
      vecs[1] = '{1'b1, 4'b1111, 2, 4'b0100, 16'd3};
      vecs[2] = '{1'b1, 4'b1111, 2, 4'b1000, 16'd4};
      vecs[3] = '{1'b1, 4'b1111, 2, 4'b0001, 16'd5};
      vecs[4] = '{1'b1, 4'b0110, 1, 4'b0010, 16'd6};
      vecs[5] = '{1'b1, 4'b0110, 0, 4'b0100, 16'd7};
      vecs[6] = '{1'b1, 4'b1001, 3, 4'b1000, 16'd8};
      vecs[7] = '{1'b1, 4'b1001, 1, 4'b0001, 16'd9};

      Reset_n = 1'b0;
      en      = 1'b1;
      req     = 4'b1111;
      ack     = 4'd0;
      model_reset();
      repeat (3) tick();
      check("rst_grant", 32'(bus_if.grant), 32'd0);
      check("rst_count", 32'(bus_if.spawn_count), 32'd0);
      check("rst_busy",  32'(bus_if.busy), 32'd1);

      // After reset is released, all monsters request and the first grant appears on the ninth edge.
      Reset_n = 1'b1;
      repeat (8) tick();
      check("t1_no_grant_before_gap", 32'(bus_if.grant), 32'd0);
      tick();
      check("t1_first_grant", 32'(bus_if.grant), 32'b0001);
      repeat (2) tick();
      ack = 4'b0001;
      tick();
      ack = 4'd0;
      check("t1_count1", 32'(bus_if.spawn_count), 32'd1);

      for (int i = 0; i < 8; i++) begin
         en  = vecs[i].en;
         req = vecs[i].req;
         serve(vecs[i].exp_grant, vecs[i].delay, $sformatf("vec%0d_grant", i));
         check($sformatf("vec%0d_count", i), 32'(bus_if.spawn_count), 32'(vecs[i].exp_count));
      end

      // Only monster 2 requests and never sends ack, so its grant times out.
      req = 4'b0100;
      wait_grant("t2");
      check("t2_grant", 32'(bus_if.grant), 32'b0100);
      for (int i = 0; i < 15; i++) begin
         tick();
         check("t2_hold", 32'(bus_if.grant), 32'b0100);
      end
      tick();
      check("t2_drop",  32'(bus_if.grant), 32'd0);
      check("t2_pulse", 32'(bus_if.timeout_pulse), 32'd1);
      check("t2_count", 32'(bus_if.spawn_count), 32'd9);
      tick();
      check("t2_pulse_once", 32'(bus_if.timeout_pulse), 32'd0);

      // Wrong ack bits are ignored, and an ack in the last timeout cycle still counts as a spawn.
      wait_grant("t3");
      check("t3_grant", 32'(bus_if.grant), 32'b0100);
      ack = 4'b1011;
      tick();
      ack = 4'd0;
      repeat (14) tick();
      check("t3_hold", 32'(bus_if.grant), 32'b0100);
      ack = 4'b0100;
      tick();
      ack = 4'd0;
      check("t3_drop",     32'(bus_if.grant), 32'd0);
      check("t3_no_pulse", 32'(bus_if.timeout_pulse), 32'd0);
      check("t3_count",    32'(bus_if.spawn_count), 32'd10);

      // With enable low, the block idles with requests pending; raising enable grants on the next edge.
      en  = 1'b0;
      req = 4'b1111;
      n   = 0;
      while (bus_if.busy && n < 100) begin
         tick();
         n++;
      end
      check("t4_idle_wait", 32'(n < 100), 32'd1);
      repeat (4) tick();
      check("t4_no_grant", 32'(bus_if.grant), 32'd0);
      check("t4_busy",     32'(bus_if.busy), 32'd0);
      check("t4_dbg_idle", 32'(dbg_state), 32'd0);
      en = 1'b1;
      tick();
      check("t4_grant", 32'(bus_if.grant), 32'b1000);
      ack = 4'b1000;
      tick();
      ack = 4'd0;
      check("t4_count", 32'(bus_if.spawn_count), 32'd11);

      // Reset during a grant clears grant and spawn_count asynchronously.
      req = 4'b0010;
      wait_grant("t5");
      check("t5_grant", 32'(bus_if.grant), 32'b0010);
      tick();
      Reset_n = 1'b0;
      #2;
      model_reset();
      check("t5_async_grant", 32'(bus_if.grant), 32'd0);
      check("t5_async_count", 32'(bus_if.spawn_count), 32'd0);
      req = 4'b1111;
      repeat (2) tick();
      Reset_n = 1'b1;
      repeat (8) tick();
      check("t5_no_grant", 32'(bus_if.grant), 32'd0);
      tick();
      check("t5_first_grant", 32'(bus_if.grant), 32'b0001);
      ack = 4'b0001;
      tick();
      ack = 4'd0;
      check("t5_count", 32'(bus_if.spawn_count), 32'd1);

      // Preload spawn_count close to the top of its range to check that it saturates.
      force dut.r_spawn_count = 16'hFFFE;
      #1;
      release dut.r_spawn_count;
      m_count = 16'hFFFE;
      serve(4'b0010, 1, "t6_g0");
      check("t6_count0", 32'(bus_if.spawn_count), 32'hFFFF);
      serve(4'b0100, 1, "t6_g1");
      check("t6_count1", 32'(bus_if.spawn_count), 32'hFFFF);
      serve(4'b1000, 1, "t6_g2");
      check("t6_count2", 32'(bus_if.spawn_count), 32'hFFFF);

      for (int i = 0; i < 1500; i++) begin
         en  = ($urandom_range(0, 9) != 0);
         req = 4'($urandom_range(0, 15));
         r   = $urandom_range(0, 9);
         if (r < 3)                        ack = 4'($urandom_range(0, 15));
         else if (r < 5 && m_owner >= 0)   ack = 4'(1 << m_owner);
         else                              ack = 4'd0;
         tick();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
